ultrasonic_echo_model: RTL and testbench
========================================

ULTRASONIC_ECHO_MODEL -- requirements
Module: ultrasonic_echo_model

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter TRIG_MIN, default 500, SHALL set the trigger-high qualification length in cycles (10 us at 20 ns).
REQ-003 Parameter BURST_DLY, default 10000, SHALL set the cycles from trigger fall to echo rise (8 x 40 kHz burst).
REQ-004 Parameter ECHO_MAX, default 1900000, SHALL set the no-object echo length in cycles (38 ms).
REQ-005 Parameter HOLDOFF, default 2500000, SHALL set the dead time after echo fall in cycles (50 ms).
REQ-006 clk  input  1  system clock, 50 MHz.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 trig  input  1  trigger from the measuring controller, synchronous to clk.
REQ-009 dist_cycles  input  32  programmed echo length in cycles.
REQ-010 dist_load  input  1  one-cycle strobe capturing dist_cycles into the target register.
REQ-011 echo  output  1  emulated sensor echo, registered.
REQ-012 busy  output  1  high in every state except IDLE and TRIG_HI.
REQ-013 trig_err  output  1  one-cycle pulse on a too-short trigger.

Function
REQ-014 The FSM SHALL have states IDLE, TRIG_HI, WAIT_FALL, BURST, ECHO, HOLD.
REQ-015 IDLE SHALL go to TRIG_HI when trig=1, with trig_cnt cleared and then counting each high cycle.
REQ-016 In TRIG_HI, trig=0 before trig_cnt reaches TRIG_MIN SHALL return to IDLE and pulse trig_err in the next cycle.
REQ-017 In TRIG_HI, trig_cnt reaching TRIG_MIN SHALL go to WAIT_FALL, so the minimum qualifying pulse is exactly TRIG_MIN cycles high.
REQ-018 WAIT_FALL SHALL hold until trig=0, then enter BURST, capturing the target register into echo_len.
REQ-019 A target register of 0 or greater than ECHO_MAX SHALL capture echo_len = ECHO_MAX (no object).
REQ-020 BURST SHALL last exactly BURST_DLY cycles, then enter ECHO.
REQ-021 echo SHALL be 1 for exactly echo_len consecutive cycles in ECHO, then 0, with the state entering HOLD.
REQ-022 HOLD SHALL last exactly HOLDOFF cycles, then enter IDLE.
REQ-023 trig activity in WAIT_FALL (after the fall), BURST, ECHO and HOLD SHALL be ignored, with no trig_err.
REQ-024 trig held high through the end of HOLD SHALL NOT qualify; a new cycle needs a trig rising edge seen in IDLE.
REQ-025 dist_load SHALL update the target register in any state; an in-flight measurement SHALL keep its captured echo_len.
REQ-026 All counters SHALL be 32-bit and unsigned, clear on state entry, and never wrap.
REQ-027 echo, busy and trig_err SHALL be driven from flops, with no combinational path from trig.

Reset
REQ-028 Reset SHALL force state IDLE, echo=0, busy=0, trig_err=0, all counters 0 and the target register 0.
REQ-029 Reset asserted mid-ECHO SHALL drop echo asynchronously, and the first measurement after release SHALL require a fresh full trigger.

Structure
REQ-030 The state encoding and the default TRIG_MIN/BURST_DLY/ECHO_MAX/HOLDOFF constants SHALL live in the shared sonar package, which the supersonic measurer also uses.
REQ-031 One sub-module, sonar_down_counter (load, enable, zero flag, 32-bit), SHALL be instantiated for the BURST/ECHO/HOLD timing.

Verification (sim parameters TRIG_MIN=5, BURST_DLY=8, ECHO_MAX=40, HOLDOFF=20)
REQ-032 Load 12, trig high 5 cycles then low -> echo rises 8 cycles after the trig fall, stays high exactly 12 cycles, and busy drops 20 cycles after the echo fall.
REQ-033 trig high 4 cycles -> trig_err pulses once, echo stays 0, and state returns to IDLE.
REQ-034 Load 0, then load 41, each with a valid trigger -> each echo is 40 cycles.
REQ-035 Valid trigger, then trig pulses during BURST and HOLD plus dist_load of 3 during ECHO -> echo length unchanged, no trig_err, and the next measurement uses 3.
REQ-036 rst_n low for 2 cycles mid-ECHO -> echo low immediately, all outputs at reset values, and a full trigger is required before the next echo.
REQ-037 trig held high continuously from the first trigger -> exactly one echo, no retrigger after HOLD until trig falls and rises again.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared sonar definitions: FSM state encoding, default timing constants and
// the echo-length clamp used by the echo emulator and the supersonic measurer.
package sonar_pkg;

    localparam int unsigned SONAR_CNT_W    = 32;
    localparam int unsigned SONAR_TRIG_MIN = 500;
    localparam int unsigned SONAR_BURST_DLY = 10000;
    localparam int unsigned SONAR_ECHO_MAX = 1900000;
    localparam int unsigned SONAR_HOLDOFF  = 2500000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG_HI   = 3'd1,
        ST_WAIT_FALL = 3'd2,
        ST_BURST     = 3'd3,
        ST_ECHO      = 3'd4,
        ST_HOLD      = 3'd5
    } sonar_state_e;

    // A zero or out-of-range target means "no object": report the full echo.
    function automatic logic [SONAR_CNT_W-1:0] clamp_echo_len(
        input logic [SONAR_CNT_W-1:0] target,
        input logic [SONAR_CNT_W-1:0] echo_max
    );
        if ((target == '0) || (target > echo_max)) begin
            return echo_max;
        end
        return target;
    endfunction

endpackage

// File: rtl/sonar_down_counter.sv
// Loadable 32-bit down-counter with terminal-count flag; stops at zero.
module sonar_down_counter
    import sonar_pkg::*;
#(
    parameter int unsigned W = SONAR_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/ultrasonic_echo_model.sv
// Behavioural-timing emulator of an ultrasonic ranging sensor: qualifies a
// trigger pulse, waits out the burst, then plays back a programmed echo width.
//
// state        | meaning
// -------------+--------------------------------------------------------------
// ST_IDLE      | waiting for a trig rising edge
// ST_TRIG_HI   | counting trig high cycles toward TRIG_MIN
// ST_WAIT_FALL | trigger qualified, waiting for trig to drop
// ST_BURST     | BURST_DLY cycles of simulated transmit burst
// ST_ECHO      | echo high for echo_len cycles
// ST_HOLD      | HOLDOFF cycles of dead time, trig ignored
module ultrasonic_echo_model
    import sonar_pkg::*;
#(
    parameter int unsigned TRIG_MIN  = SONAR_TRIG_MIN,
    parameter int unsigned BURST_DLY = SONAR_BURST_DLY,
    parameter int unsigned ECHO_MAX  = SONAR_ECHO_MAX,
    parameter int unsigned HOLDOFF   = SONAR_HOLDOFF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   trig,
    input  logic [SONAR_CNT_W-1:0] dist_cycles,
    input  logic                   dist_load,
    output logic                   echo,
    output logic                   busy,
    output logic                   trig_err
);

    localparam logic [SONAR_CNT_W-1:0] TRIG_MIN_C = SONAR_CNT_W'(TRIG_MIN);
    localparam logic [SONAR_CNT_W-1:0] ECHO_MAX_C = SONAR_CNT_W'(ECHO_MAX);
    localparam logic [SONAR_CNT_W-1:0] BURST_LOAD = SONAR_CNT_W'(BURST_DLY - 1);
    localparam logic [SONAR_CNT_W-1:0] HOLD_LOAD  = SONAR_CNT_W'(HOLDOFF - 1);

    sonar_state_e           state_q, state_d;
    logic [SONAR_CNT_W-1:0] trig_cnt_q, trig_cnt_d;
    logic [SONAR_CNT_W-1:0] target_q, target_d;
    logic [SONAR_CNT_W-1:0] echo_len_q, echo_len_d;
    logic [SONAR_CNT_W-1:0] trig_inc;
    logic                   trig_prev_q, trig_prev_d;
    logic                   echo_q, echo_d;
    logic                   busy_q, busy_d;
    logic                   trig_err_q, trig_err_d;

    logic                   cnt_load;
    logic [SONAR_CNT_W-1:0] cnt_load_val;
    logic                   cnt_en;
    logic                   cnt_zero;

    sonar_down_counter #(
        .W (SONAR_CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    assign trig_inc = (trig_cnt_q == '1) ? trig_cnt_q : trig_cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        trig_cnt_d   = trig_cnt_q;
        echo_len_d   = echo_len_q;
        target_d     = dist_load ? dist_cycles : target_q;
        trig_prev_d  = trig;
        trig_err_d   = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Edge, not level: a trig left high across HOLD or reset must not rearm.
                if (trig && !trig_prev_q) begin
                    trig_cnt_d = SONAR_CNT_W'(1);
                    state_d    = (TRIG_MIN_C <= SONAR_CNT_W'(1)) ? ST_WAIT_FALL : ST_TRIG_HI;
                end
            end
            ST_TRIG_HI: begin
                if (!trig) begin
                    trig_cnt_d = '0;
                    trig_err_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    trig_cnt_d = trig_inc;
                    if (trig_inc >= TRIG_MIN_C) begin
                        state_d = ST_WAIT_FALL;
                    end
                end
            end
            ST_WAIT_FALL: begin
                if (!trig) begin
                    trig_cnt_d   = '0;
                    echo_len_d   = clamp_echo_len(target_q, ECHO_MAX_C);
                    cnt_load     = 1'b1;
                    cnt_load_val = BURST_LOAD;
                    state_d      = ST_BURST;
                end
            end
            ST_BURST: begin
                cnt_en = 1'b1;
                if (cnt_zero) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = echo_len_q - 1'b1;
                    state_d      = ST_ECHO;
                end
            end
            ST_ECHO: begin
                cnt_en = 1'b1;
                if (cnt_zero) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = HOLD_LOAD;
                    state_d      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                cnt_en = 1'b1;
                if (cnt_zero) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = '0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        echo_d = (state_d == ST_ECHO);
        busy_d = (state_d != ST_IDLE) && (state_d != ST_TRIG_HI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            trig_cnt_q  <= '0;
            target_q    <= '0;
            echo_len_q  <= '0;
            trig_prev_q <= 1'b1;
            echo_q      <= 1'b0;
            busy_q      <= 1'b0;
            trig_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            trig_cnt_q  <= trig_cnt_d;
            target_q    <= target_d;
            echo_len_q  <= echo_len_d;
            trig_prev_q <= trig_prev_d;
            echo_q      <= echo_d;
            busy_q      <= busy_d;
            trig_err_q  <= trig_err_d;
        end
    end

    assign echo     = echo_q;
    assign busy     = busy_q;
    assign trig_err = trig_err_q;

endmodule

// File: tb/tb_ultrasonic_echo_model.sv
// Directed + randomized bench for ultrasonic_echo_model with a timing-level
// reference model of trigger qualification, burst delay, echo width and holdoff.
module tb_ultrasonic_echo_model;

    localparam int unsigned P_TRIG_MIN  = 5;
    localparam int unsigned P_BURST_DLY = 8;
    localparam int unsigned P_ECHO_MAX  = 40;
    localparam int unsigned P_HOLDOFF   = 20;
    localparam int          BOUND       = 200;

    logic        clk;
    logic        rst_n;
    logic        trig;
    logic [31:0] dist_cycles;
    logic        dist_load;
    logic        echo;
    logic        busy;
    logic        trig_err;

    int total = 0;
    int bad   = 0;
    logic [31:0] target_m;

    ultrasonic_echo_model #(
        .TRIG_MIN  (P_TRIG_MIN),
        .BURST_DLY (P_BURST_DLY),
        .ECHO_MAX  (P_ECHO_MAX),
        .HOLDOFF   (P_HOLDOFF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trig        (trig),
        .dist_cycles (dist_cycles),
        .dist_load   (dist_load),
        .echo        (echo),
        .busy        (busy),
        .trig_err    (trig_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] exp_len(input logic [31:0] d);
        return ((d == 0) || (d > P_ECHO_MAX)) ? 32'(P_ECHO_MAX) : d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_dist(input logic [31:0] v);
        dist_cycles = v;
        dist_load   = 1'b1;
        target_m    = v;
        tick();
        dist_load   = 1'b0;
    endtask

    // mode 0: trig quiet; 1: random trig chatter while busy; 2: trig re-raised in BURST and held
    task automatic drive_busy(input int mode);
        if (mode == 1) trig = 1'($urandom_range(0, 1));
        else if (mode == 2) trig = 1'b1;
    endtask

    task automatic measure(input int hi, input int mode, input int mid_load);
        int          n;
        logic        errseen;
        logic [31:0] expect_len;
        expect_len = exp_len(target_m);
        errseen    = 1'b0;
        trig = 1'b1;
        repeat (hi) tick();
        trig = 1'b0;

        // One cycle to register the fall, then BURST_DLY cycles of burst.
        n = 0;
        while (n < BOUND) begin
            tick();
            n++;
            if (trig_err) errseen = 1'b1;
            if (echo) break;
            drive_busy(mode);
        end
        chk("rise_latency", n, P_BURST_DLY + 1);

        n = 1;
        while (n < BOUND) begin
            if ((mid_load >= 0) && (n == 2)) begin
                dist_cycles = 32'(mid_load);
                dist_load   = 1'b1;
                target_m    = 32'(mid_load);
            end else begin
                dist_load = 1'b0;
            end
            drive_busy(mode);
            tick();
            if (trig_err) errseen = 1'b1;
            if (!echo) break;
            n++;
        end
        dist_load = 1'b0;
        chk("echo_len", n, expect_len);
        chk("busy_at_echo_fall", busy, 1);

        n = 0;
        while (n < BOUND) begin
            if (mode == 1) trig = (n < P_HOLDOFF - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            else drive_busy(mode);
            tick();
            n++;
            if (trig_err) errseen = 1'b1;
            if (echo) errseen = 1'b1;
            if (!busy) break;
        end
        chk("holdoff_len", n, P_HOLDOFF);
        chk("no_err_or_reecho", errseen, 0);
        if (mode != 2) trig = 1'b0;
    endtask

    task automatic short_trig(input int hi);
        int pulses;
        int activity;
        trig = 1'b1;
        repeat (hi) tick();
        trig = 1'b0;
        tick();
        chk("short_err_pulse", trig_err, 1);
        pulses   = 1;
        activity = 0;
        repeat (20) begin
            tick();
            if (trig_err) pulses++;
            if (echo || busy) activity++;
        end
        chk("short_err_count", pulses, 1);
        chk("short_no_echo_busy", activity, 0);
    endtask

    initial begin
        int seen;
        rst_n       = 1'b0;
        trig        = 1'b0;
        dist_cycles = '0;
        dist_load   = 1'b0;
        target_m    = '0;
        #1;
        chk("rst_echo", echo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_trig_err", trig_err, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        load_dist(12);
        measure(5, 0, -1);

        short_trig(4);
        for (int i = 1; i <= 3; i++) short_trig(i);

        load_dist(0);
        measure(5, 0, -1);
        load_dist(41);
        measure(6, 0, -1);

        for (int i = 0; i < 6; i++) begin
            load_dist(32'($urandom_range(0, 50)));
            tick();
            measure(int'($urandom_range(5, 9)), int'($urandom_range(0, 1)), -1);
            tick();
        end

        load_dist(15);
        measure(5, 1, 3);
        tick();
        measure(7, 0, -1);

        load_dist(30);
        trig = 1'b1;
        repeat (5) tick();
        trig = 1'b0;
        repeat (P_BURST_DLY + 1 + 5) tick();
        chk("pre_reset_echo", echo, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_echo", echo, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_trig_err", trig_err, 0);
        trig = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        target_m = '0;
        seen = 0;
        repeat (10) begin
            tick();
            if (busy || echo || trig_err) seen++;
        end
        chk("no_start_from_held_trig", seen, 0);
        trig = 1'b0;
        tick();
        measure(6, 0, -1);

        tick();
        load_dist(9);
        measure(5, 2, -1);
        seen = 0;
        repeat (30) begin
            tick();
            if (busy || echo || trig_err) seen++;
        end
        chk("no_retrigger_held_high", seen, 0);
        trig = 1'b0;
        tick();
        measure(5, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
